// File: rtl/ps2_timeout_monitor.sv
// Per-channel PS/2 inactivity timeout counters with a shared tick.
// Define PS2_TIMEOUT_PRESCALE_EN to build the shared PRESCALE tick divider.
module ps2_timeout_monitor #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 15,
  parameter int TIMEOUT     = 30000,
  parameter int AUTO_RELOAD = 0,
  parameter int PRESCALE    = 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         kick,
  input  logic [NCH-1:0]         clr,
  output logic [NCH-1:0]         timeout_pulse,
  output logic [NCH-1:0]         expired,
  output logic [NCH*CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT);

  logic                      tick;
  logic [NCH-1:0]            term;
  logic [NCH-1:0][CNT_W-1:0] q;

`ifdef PS2_TIMEOUT_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge sys_clk) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 16'd1;
  end
`else
  logic unused_prescale;

  assign tick            = 1'b1;
  assign unused_prescale = (PRESCALE == 0);
`endif

  // Terminal tick: kick and !en outrank expiry, so they mask it here.
  always_comb begin
    term = '0;
    for (int unsigned i = 0; i < NCH; i++)
      term[i] = tick && en[i] && !kick[i] && (q[i] == TERM);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      q             <= '0;
      timeout_pulse <= '0;
      expired       <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        timeout_pulse[i] <= term[i];
        if (kick[i] || !en[i]) begin
          q[i] <= '0;
        end else if (term[i]) begin
          if (AUTO_RELOAD != 0) q[i] <= '0;
          else                  q[i] <= TOP;
        end else if (tick && (q[i] < TERM)) begin
          q[i] <= q[i] + 1'b1;
        end
        if (term[i])     expired[i] <= 1'b1;
        else if (clr[i]) expired[i] <= 1'b0;
      end
    end
  end

  assign count = q;

endmodule

// File: tb/tb_ps2_timeout_monitor.sv
// Bench: four monitor configurations checked every cycle against an
// elapsed-tick reference model, plus directed scenario checks.
module tb_ps2_timeout_monitor;

  localparam int NI = 4;
`ifdef PS2_TIMEOUT_PRESCALE_EN
  localparam int PSC = 4;
`else
  localparam int PSC = 1;
`endif
  localparam int TO [NI] = '{5, 3, 2, 1};
  localparam bit AR [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam int CW [NI] = '{15, 15, 15, 1};
  localparam int PS [NI] = '{1, 1, PSC, 1};

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [1:0]  en   [NI];
  logic [1:0]  kick [NI];
  logic [1:0]  clr  [NI];
  logic [1:0]  tp   [NI];
  logic [1:0]  ex   [NI];
  logic [29:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  int total = 0;
  int bad   = 0;

  // reference model: enabled ticks elapsed since the last restart
  int age    [NI][2];
  bit mpulse [NI][2];
  bit mexp   [NI][2];
  int mcyc   [NI];

  int npulse [NI][2];
  int first  [NI][2];
  int since_rst;

  always #5 sys_clk = ~sys_clk;

  ps2_timeout_monitor #(.NCH(2), .CNT_W(15), .TIMEOUT(5), .AUTO_RELOAD(0), .PRESCALE(1)) u_a (
    .sys_clk(sys_clk), .reset(reset), .en(en[0]), .kick(kick[0]), .clr(clr[0]),
    .timeout_pulse(tp[0]), .expired(ex[0]), .count(cnt0));
  ps2_timeout_monitor #(.NCH(2), .CNT_W(15), .TIMEOUT(3), .AUTO_RELOAD(1), .PRESCALE(1)) u_b (
    .sys_clk(sys_clk), .reset(reset), .en(en[1]), .kick(kick[1]), .clr(clr[1]),
    .timeout_pulse(tp[1]), .expired(ex[1]), .count(cnt1));
  ps2_timeout_monitor #(.NCH(2), .CNT_W(15), .TIMEOUT(2), .AUTO_RELOAD(0), .PRESCALE(PSC)) u_c (
    .sys_clk(sys_clk), .reset(reset), .en(en[2]), .kick(kick[2]), .clr(clr[2]),
    .timeout_pulse(tp[2]), .expired(ex[2]), .count(cnt2));
  ps2_timeout_monitor #(.NCH(2), .CNT_W(1), .TIMEOUT(1), .AUTO_RELOAD(0), .PRESCALE(1)) u_d (
    .sys_clk(sys_clk), .reset(reset), .en(en[3]), .kick(kick[3]), .clr(clr[3]),
    .timeout_pulse(tp[3]), .expired(ex[3]), .count(cnt3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] get_q(input int k, input int c);
    logic [63:0] v;
    case (k)
      0:       v = 64'(cnt0);
      1:       v = 64'(cnt1);
      2:       v = 64'(cnt2);
      default: v = 64'(cnt3);
    endcase
    return (v >> (c * CW[k])) & ((64'd1 << CW[k]) - 64'd1);
  endfunction

  function automatic int exp_q(input int k, input int c);
    if (AR[k]) return age[k][c] % TO[k];
    return (age[k][c] < TO[k]) ? age[k][c] : TO[k];
  endfunction

  task automatic step();
    @(posedge sys_clk);
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (reset) begin
          age[k][c] = 0; mpulse[k][c] = 0; mexp[k][c] = 0;
        end else begin
          bit tick;
          bit trm;
          tick = ((mcyc[k] % PS[k]) == PS[k] - 1);
          trm  = 0;
          if (kick[k][c])     age[k][c] = 0;
          else if (!en[k][c]) age[k][c] = 0;
          else if (tick) begin
            age[k][c]++;
            trm = AR[k] ? ((age[k][c] % TO[k]) == 0) : (age[k][c] == TO[k]);
          end
          mpulse[k][c] = trm;
          if (trm)             mexp[k][c] = 1;
          else if (clr[k][c])  mexp[k][c] = 0;
        end
      end
      mcyc[k] = reset ? 0 : mcyc[k] + 1;
    end
    since_rst = reset ? 0 : since_rst + 1;
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("q%0d_%0d", k, c), get_q(k, c), 64'(exp_q(k, c)));
        chk($sformatf("pulse%0d_%0d", k, c), 64'(tp[k][c]), 64'(mpulse[k][c]));
        chk($sformatf("exp%0d_%0d", k, c), 64'(ex[k][c]), 64'(mexp[k][c]));
        if (tp[k][c] === 1'b1) begin
          npulse[k][c]++;
          if (first[k][c] < 0) first[k][c] = since_rst;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      en[k] = 2'b00; kick[k] = 2'b00; clr[k] = 2'b00;
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 2; c++) begin
        npulse[k][c] = 0; first[k][c] = -1;
      end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_tp0", 64'(tp[0]), 64'd0);
    chk("rst_ex0", 64'(ex[0]), 64'd0);

    // one-shot expiry, periodic reload with clr, prescaled and TIMEOUT=1 instances
    for (int k = 0; k < NI; k++) en[k] = 2'b11;
    for (int i = 1; i <= 25; i++) begin
      clr[1] = (i == 5 || i == 6) ? 2'b01 : 2'b00;
      step();
      if (i == 5) chk("b_clr_clears", 64'(ex[1][0]), 64'd0);
      if (i == 6) chk("b_set_beats_clr", 64'(ex[1][0]), 64'd1);
    end
    clr[1] = 2'b00;
    chk("a_first_pulse", 64'(first[0][0]), 64'd5);
    chk("a_one_pulse", 64'(npulse[0][0]), 64'd1);
    chk("a_ch1_one_pulse", 64'(npulse[0][1]), 64'd1);
    chk("a_q_hold", get_q(0, 0), 64'd5);
    chk("a_expired", 64'(ex[0][0]), 64'd1);
    chk("b_periodic_pulses", 64'(npulse[1][1]), 64'd8);
    chk("c_first_pulse", 64'(first[2][0]), 64'(2 * PSC));
    chk("c_one_pulse", 64'(npulse[2][0]), 64'd1);
    chk("d_first_pulse", 64'(first[3][0]), 64'd1);

    // kick ch0 every 4 cycles: it never expires, ch1 still does
    do_reset();
    en[0] = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      kick[0] = (i % 4 == 0) ? 2'b01 : 2'b00;
      step();
    end
    kick[0] = 2'b00;
    chk("kick_no_pulse", 64'(npulse[0][0]), 64'd0);
    chk("kick_no_expired", 64'(ex[0][0]), 64'd0);
    chk("kick_ch1_at5", 64'(first[0][1]), 64'd5);

    // kick coincident with terminal tick, then en drop at q=3
    do_reset();
    en[0] = 2'b11;
    repeat (4) step();
    kick[0] = 2'b01;
    step();
    kick[0] = 2'b00;
    chk("kick_term_q", get_q(0, 0), 64'd0);
    chk("kick_term_pulse", 64'(tp[0][0]), 64'd0);
    chk("kick_term_exp", 64'(ex[0][0]), 64'd0);
    chk("kick_term_ch1", 64'(tp[0][1]), 64'd1);
    repeat (3) step();
    chk("q_at3", get_q(0, 0), 64'd3);
    en[0] = 2'b10;
    step();
    chk("en_drop_q", get_q(0, 0), 64'd0);
    en[0] = 2'b11;
    step();
    chk("reenable_q", get_q(0, 0), 64'd1);

    // reset mid-count aborts everything
    do_reset();
    for (int k = 0; k < NI; k++) en[k] = 2'b11;
    repeat (PSC) step();
    chk("c_q_is1", get_q(2, 0), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_cnt2", 64'(cnt2), 64'd0);
    chk("midrst_tp2", 64'(tp[2]), 64'd0);
    chk("midrst_ex3", 64'(ex[3]), 64'd0);
    chk("midrst_cnt0", 64'(cnt0), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NI; k++) begin
        en[k]   = 2'($urandom) | (($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00);
        kick[k] = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
        clr[k]  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_timeout_monitor.md
PS2_TIMEOUT_MONITOR -- requirements
Module: ps2_timeout_monitor

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of independent timeout channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 15, per-channel counter width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 30000, terminal count in ticks (1 <= TIMEOUT <= 2^CNT_W-1).
REQ-004 The block SHALL have parameter AUTO_RELOAD, default 0, where 0 selects one-shot mode and 1 selects periodic mode, common to all channels.
REQ-005 The block SHALL have parameter PRESCALE, default 1, sys_clk cycles per tick (1..65535), used only when the prescaler is compiled in.
REQ-006 The block SHALL have port sys_clk  input  1  system clock; all logic rising-edge.
REQ-007 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 The block SHALL have port en  input  NCH  per-channel enable; when low, the channel counter is held at 0.
REQ-009 The block SHALL have port kick  input  NCH  per-channel restart; any PS/2 edge or byte strobe.
REQ-010 The block SHALL have port clr  input  NCH  per-channel clear of the sticky expired flag.
REQ-011 The block SHALL have port timeout_pulse  output  NCH  one-sys_clk-cycle strobe on expiry.
REQ-012 The block SHALL have port expired  output  NCH  sticky expiry flag.
REQ-013 The block SHALL have port count  output  NCH*CNT_W  concatenated channel counters, channel 0 in the LSBs.

Function
REQ-014 Each channel SHALL keep a CNT_W-bit counter q; all outputs SHALL be registered.
REQ-015 tick SHALL be 1 every cycle without the prescaler, and one cycle in every PRESCALE cycles with it.
REQ-016 Per-channel priority SHALL be: reset > kick > !en > terminal tick > tick > hold.
REQ-017 On kick, q SHALL become 0 next cycle, regardless of en, tick or current q.
REQ-018 With en low and no kick, q SHALL become 0.
REQ-019 On a tick with en high and q < TIMEOUT-1, q SHALL increment by 1.
REQ-020 Terminal tick (tick, en high, no kick, q == TIMEOUT-1): timeout_pulse SHALL be 1 next cycle for exactly one cycle, and expired SHALL set.
REQ-021 On a terminal tick in one-shot mode, q SHALL become TIMEOUT and hold there; no further pulses until kick or en low.
REQ-022 On a terminal tick in periodic mode, q SHALL become 0, giving one pulse every TIMEOUT ticks while un-kicked.
REQ-023 expired SHALL clear only on clr or reset; a simultaneous set and clr SHALL leave expired at 1.
REQ-024 Kick on the same cycle as a terminal tick SHALL win: q becomes 0, no pulse, expired unchanged.
REQ-025 TIMEOUT = 1 SHALL pulse on the first tick after kick (one-shot) or on every tick (periodic).
REQ-026 The counter SHALL never wrap past TIMEOUT.
REQ-027 Channels SHALL be fully independent except for the shared tick.

Reset
REQ-028 While reset is high at a sys_clk edge, every q, the prescaler counter, timeout_pulse and expired SHALL become 0.
REQ-029 Reset mid-count or mid-pulse SHALL abort with no pulse in the following cycle.
REQ-030 The first increment after reset release SHALL occur on the first tick with en high.

Configuration
REQ-031 Macro PS2_TIMEOUT_PRESCALE_EN SHALL select the prescaler build.
REQ-032 With the macro defined: a shared 16-bit prescaler counts 0..PRESCALE-1 and asserts tick when it is PRESCALE-1; PRESCALE = 1 behaves like tick every cycle; the prescaler is not affected by kick, en or clr.
REQ-033 With the macro undefined: no prescaler logic is built, tick = 1 every cycle, and PRESCALE is ignored.

Verification
REQ-034 Bench SHALL check: NCH=2, TIMEOUT=5, one-shot, en=11, no kick -> ch0 pulse one cycle after 5th tick, q holds 5, expired=1, no second pulse in 20 cycles.
REQ-035 Bench SHALL check: same configuration, kick ch0 every 4 cycles -> no pulse, expired stays 0; ch1 still expires at cycle 5.
REQ-036 Bench SHALL check: AUTO_RELOAD=1, TIMEOUT=3 -> pulses every 3 cycles; clr asserted on a pulse cycle -> expired stays 1.
REQ-037 Bench SHALL check: kick coincident with terminal tick -> q=0, no pulse; en dropped at q=3 -> q=0, re-enable restarts from 0.
REQ-038 Bench SHALL check: macro defined, PRESCALE=4, TIMEOUT=2 -> pulse 8 cycles after reset release; reset asserted at q=1 -> all outputs 0 next cycle.
